peri_bus_arbiter: RTL and testbench



---
 rtl/peri_arb_pkg.sv | 24 ++
 rtl/peri_rr_pick.sv | 47 ++++
 rtl/peri_bus_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_peri_bus_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/peri_arb_pkg.sv
// ---------------------------------------------------------------------------
// peri_arb_pkg
// Shared definitions for the peripheral bus arbiter:
//   - arbState_e : arbiter FSM states (IDLE, REQ, WAIT_R)
//   - ERR_RDATA  : read data returned to a master when the response
//                  watchdog gives up (only used with PERI_ARB_TIMEOUT_EN)
//   - ownerWidth : width of a master index for a given master count
// ---------------------------------------------------------------------------
package peri_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      WAIT_R = 2'd2
   } arbState_e;

   localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

   // Never returns 0 so that index vectors stay at least one bit wide.
   function automatic int ownerWidth(input int numMasters);
      return (numMasters > 1) ? $clog2(numMasters) : 1;
   endfunction

endpackage

// File: rtl/peri_rr_pick.sv
// ---------------------------------------------------------------------------
// peri_rr_pick
// Purely combinational round-robin pick. Scans the request vector starting
// at ptr_i and wrapping at NUM_MASTERS-1 back to 0; the first set request
// wins.
// Ports:
//   req_i      in  NUM_MASTERS  request vector
//   ptr_i      in  IW           index the search starts at
//   winIdx_o   out IW           index of the winning requester
//   anyValid_o out 1            at least one request is set
// ---------------------------------------------------------------------------
module peri_rr_pick
   import peri_arb_pkg::*;
#(
   parameter  int NUM_MASTERS = 2,
   localparam int IW          = ownerWidth(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] req_i,
   input  logic [IW-1:0]          ptr_i,
   output logic [IW-1:0]          winIdx_o,
   output logic                   anyValid_o
);

   int cand;

   // Visit candidates in priority order ptr, ptr+1, ... (mod NUM_MASTERS).
   // The inner loop turns the computed candidate back into a constant index
   // so the request vector is only ever indexed by loop constants.
   always_comb begin
      winIdx_o   = '0;
      anyValid_o = 1'b0;
      cand       = 0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         cand = int'(ptr_i) + i;
         if (cand >= NUM_MASTERS) begin
            cand = cand - NUM_MASTERS;
         end
         for (int j = 0; j < NUM_MASTERS; j++) begin
            if (!anyValid_o && (j == cand) && req_i[j]) begin
               anyValid_o = 1'b1;
               winIdx_o   = IW'(j);
            end
         end
      end
   end

endmodule

// File: rtl/peri_bus_arbiter.sv
// ---------------------------------------------------------------------------
// peri_bus_arbiter
// Round-robin arbiter sharing the single peripheral request port between
// NUM_MASTERS requesters with exactly one outstanding transaction. The
// winning request is captured, driven downstream from registers, and the
// single response is routed back to the master that owns it.
//
// Optional feature: define PERI_ARB_TIMEOUT_EN to enable a response
// watchdog. After TIMEOUT_CYCLES WAIT_R cycles without peri_rvalid the
// owner gets an m_rvalid_o pulse carrying ERR_RDATA and timeout_o is set
// (sticky until rst). Without the macro WAIT_R waits forever and
// timeout_o is tied low.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   m_req_i       per-master request
//   m_addr_i      per-master address      (flattened, master 0 in LSBs)
//   m_write_i     per-master write enable
//   m_be_i        per-master byte enables (flattened)
//   m_wdata_i     per-master write data   (flattened)
//   m_gnt_o       one-hot grant pulse
//   m_rvalid_o    one-hot response pulse
//   m_rdata_o     response data shared by all masters
//   peri_*        downstream request port (req/addr/write/be/wdata out,
//                 gnt/rvalid/rdata in)
//   timeout_o     sticky watchdog flag
// ---------------------------------------------------------------------------
module peri_bus_arbiter
   import peri_arb_pkg::*;
#(
   parameter int NUM_MASTERS    = 2,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255,
   localparam int BE_WIDTH      = DATA_WIDTH / 8
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_MASTERS-1:0]            m_req_i,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
   input  logic [NUM_MASTERS-1:0]            m_write_i,
   input  logic [NUM_MASTERS*BE_WIDTH-1:0]   m_be_i,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata_i,
   output logic [NUM_MASTERS-1:0]            m_gnt_o,
   output logic [NUM_MASTERS-1:0]            m_rvalid_o,
   output logic [DATA_WIDTH-1:0]             m_rdata_o,
   output logic                              peri_req,
   output logic [ADDR_WIDTH-1:0]             peri_addr,
   output logic                              peri_write,
   output logic [BE_WIDTH-1:0]               peri_be,
   output logic [DATA_WIDTH-1:0]             peri_wdata,
   input  logic                              peri_gnt,
   input  logic                              peri_rvalid,
   input  logic [DATA_WIDTH-1:0]             peri_rdata,
   output logic                              timeout_o
);

   localparam int IW = ownerWidth(NUM_MASTERS);

   // Reject configurations the arbiter cannot serve at elaboration time.
   if (NUM_MASTERS < 2 || TIMEOUT_CYCLES < 1) begin : gParamCheck
      $error("peri_bus_arbiter: needs NUM_MASTERS >= 2 and TIMEOUT_CYCLES >= 1");
   end

   arbState_e             state_q, state_d;
   logic [IW-1:0]         owner_q, owner_d;
   logic [IW-1:0]         ptr_q, ptr_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  write_q, write_d;
   logic [BE_WIDTH-1:0]   be_q, be_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

   logic [IW-1:0]         pickIdx;
   logic                  pickValid;
   logic                  timeoutFire;
   logic                  respDone;
   logic [IW-1:0]         nextPtr;

   logic [ADDR_WIDTH-1:0] mAddr  [NUM_MASTERS];
   logic [BE_WIDTH-1:0]   mBe    [NUM_MASTERS];
   logic [DATA_WIDTH-1:0] mWdata [NUM_MASTERS];

   // Split the flattened payload buses into per-master arrays so the
   // capture mux can be indexed directly by the winner.
   for (genvar g = 0; g < NUM_MASTERS; g++) begin : gUnpack
      assign mAddr[g]  = m_addr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign mBe[g]    = m_be_i[g*BE_WIDTH +: BE_WIDTH];
      assign mWdata[g] = m_wdata_i[g*DATA_WIDTH +: DATA_WIDTH];
   end

   peri_rr_pick #(
      .NUM_MASTERS (NUM_MASTERS)
   ) uPick (
      .req_i      (m_req_i),
      .ptr_i      (ptr_q),
      .winIdx_o   (pickIdx),
      .anyValid_o (pickValid)
   );

`ifdef PERI_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          timeout_q, timeout_d;

   // The counter sits at zero outside WAIT_R, so it is cleared on entry and
   // counts elapsed WAIT_R cycles. A real response in the limit cycle wins
   // over the watchdog.
   always_comb begin
      cnt_d       = '0;
      timeoutFire = 1'b0;
      timeout_d   = timeout_q;
      if (state_q == WAIT_R) begin
         cnt_d = cnt_q + CW'(1);
         if ((cnt_q == CW'(TIMEOUT_CYCLES)) && !peri_rvalid) begin
            timeoutFire = 1'b1;
            timeout_d   = 1'b1;
         end
      end
   end

   // Watchdog registers; the flag stays set until reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout_o = timeout_q;
`else
   assign timeoutFire = 1'b0;
   assign timeout_o   = 1'b0;
`endif

   assign respDone = (state_q == WAIT_R) && (peri_rvalid || timeoutFire);
   assign nextPtr  = (owner_q == IW'(NUM_MASTERS - 1)) ? '0 : owner_q + IW'(1);

   // Next-state logic. The payload is captured only in IDLE so the
   // downstream port stays stable even if the master drops its request.
   // A gnt in REQ always wins; an rvalid seen in the same REQ cycle is
   // ignored, as is any rvalid outside WAIT_R.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      addr_d  = addr_q;
      write_d = write_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      case (state_q)
         IDLE: begin
            if (pickValid) begin
               owner_d = pickIdx;
               addr_d  = mAddr[pickIdx];
               write_d = m_write_i[pickIdx];
               be_d    = mBe[pickIdx];
               wdata_d = mWdata[pickIdx];
               state_d = REQ;
            end
         end
         REQ: begin
            if (peri_gnt) begin
               state_d = WAIT_R;
            end
         end
         WAIT_R: begin
            if (respDone) begin
               ptr_d   = nextPtr;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and capture registers, all cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
         addr_q  <= '0;
         write_q <= 1'b0;
         be_q    <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
      end
   end

   assign peri_req   = (state_q == REQ);
   assign peri_addr  = addr_q;
   assign peri_write = write_q;
   assign peri_be    = be_q;
   assign peri_wdata = wdata_q;

   // Grant and response pulses follow the downstream handshakes in the same
   // cycle. Read data is a passthrough, forced to zero outside WAIT_R so it
   // never leaks stale bus values, and replaced by ERR_RDATA on a timeout.
   always_comb begin
      m_gnt_o    = '0;
      m_rvalid_o = '0;
      m_rdata_o  = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         m_gnt_o[i]    = (state_q == REQ) && peri_gnt && (owner_q == IW'(i));
         m_rvalid_o[i] = respDone && (owner_q == IW'(i));
      end
      if (state_q == WAIT_R) begin
         m_rdata_o = timeoutFire ? DATA_WIDTH'(ERR_RDATA) : peri_rdata;
      end
   end

endmodule

// File: tb/tb_peri_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_peri_bus_arbiter
// Directed bench for peri_bus_arbiter (two masters). Expected responses are
// queued when a request is driven and popped when the arbiter returns the
// response. Inputs change on the falling edge, outputs are sampled 1 ns
// later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_peri_bus_arbiter;

   localparam int NM = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = DW / 8;
   localparam int TO = 8;

   typedef struct {
      int          owner;
      logic [31:0] rdata;
   } expT;

   logic              clk = 1'b0;
   logic              rst;
   logic [NM-1:0]     m_req_i;
   logic [NM*AW-1:0]  m_addr_i;
   logic [NM-1:0]     m_write_i;
   logic [NM*BW-1:0]  m_be_i;
   logic [NM*DW-1:0]  m_wdata_i;
   logic [NM-1:0]     m_gnt_o;
   logic [NM-1:0]     m_rvalid_o;
   logic [DW-1:0]     m_rdata_o;
   logic              peri_req;
   logic [AW-1:0]     peri_addr;
   logic              peri_write;
   logic [BW-1:0]     peri_be;
   logic [DW-1:0]     peri_wdata;
   logic              peri_gnt;
   logic              peri_rvalid;
   logic [DW-1:0]     peri_rdata;
   logic              timeout_o;

   logic [AW-1:0]     mAddr  [NM];
   logic [BW-1:0]     mBe    [NM];
   logic [DW-1:0]     mWdata [NM];
   logic [NM-1:0]     mWrite;

   expT               sbq[$];
   int                nAssert  = 0;
   int                nFail    = 0;
   int                modelPtr = 0;

   always #5 clk = ~clk;

   // Pack the per-master payload arrays onto the flattened buses.
   always_comb begin
      m_addr_i  = '0;
      m_be_i    = '0;
      m_wdata_i = '0;
      m_write_i = mWrite;
      for (int i = 0; i < NM; i++) begin
         m_addr_i[i*AW +: AW]  = mAddr[i];
         m_be_i[i*BW +: BW]    = mBe[i];
         m_wdata_i[i*DW +: DW] = mWdata[i];
      end
   end

   peri_bus_arbiter #(
      .NUM_MASTERS    (NM),
      .ADDR_WIDTH     (AW),
      .DATA_WIDTH     (DW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .m_req_i     (m_req_i),
      .m_addr_i    (m_addr_i),
      .m_write_i   (m_write_i),
      .m_be_i      (m_be_i),
      .m_wdata_i   (m_wdata_i),
      .m_gnt_o     (m_gnt_o),
      .m_rvalid_o  (m_rvalid_o),
      .m_rdata_o   (m_rdata_o),
      .peri_req    (peri_req),
      .peri_addr   (peri_addr),
      .peri_write  (peri_write),
      .peri_be     (peri_be),
      .peri_wdata  (peri_wdata),
      .peri_gnt    (peri_gnt),
      .peri_rvalid (peri_rvalid),
      .peri_rdata  (peri_rdata),
      .timeout_o   (timeout_o)
   );

   // Single comparison point: counts, and reports a mismatch with tag.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      nAssert++;
      assert (observed === expected) else begin
         nFail++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Drive the master requests and the downstream handshake inputs.
   task automatic applyStimulus(input logic [NM-1:0] req, input logic gnt,
                                input logic rv, input logic [31:0] rdata);
      m_req_i     = req;
      peri_gnt    = gnt;
      peri_rvalid = rv;
      peri_rdata  = rdata;
   endtask

   // Reference round robin: first requester at or after modelPtr.
   function automatic int pickModel(input logic [NM-1:0] req);
      for (int i = 0; i < NM; i++) begin
         if (req[(modelPtr + i) % NM]) return (modelPtr + i) % NM;
      end
      return 0;
   endfunction

   // One full transaction: request in IDLE, gnt after gntWait REQ cycles,
   // rvalid after rWait WAIT_R cycles. dropEarly makes the winner drop req
   // and scramble its address right after capture; rvAtGnt raises rvalid
   // together with gnt, which must be ignored.
   task automatic serveTxn(input logic [NM-1:0] reqMask, input int gntWait,
                           input int rWait, input logic [31:0] rdata,
                           input bit dropEarly, input bit rvAtGnt,
                           input string tag);
      int            w;
      logic [NM-1:0] req;
      logic [AW-1:0] savedAddr;
      expT           e;
      w   = pickModel(reqMask);
      req = reqMask;
      savedAddr = mAddr[w];
      sbq.push_back('{owner: w, rdata: rdata});
      @(negedge clk);
      applyStimulus(req, 1'b0, 1'b0, 32'h0);
      #1;
      checkOutput({tag, " idle peri_req"}, 64'(peri_req), 64'd0);
      for (int k = 0; k <= gntWait; k++) begin
         @(negedge clk);
         if (dropEarly && k == 0) begin
            req[w]   = 1'b0;
            mAddr[w] = 32'hFFFF_FFFF;
         end
         applyStimulus(req, k == gntWait, rvAtGnt && (k == gntWait), 32'hBAD0_0000);
         #1;
         checkOutput({tag, " peri_req"}, 64'(peri_req), 64'd1);
         checkOutput({tag, " peri_addr"}, 64'(peri_addr), 64'(savedAddr));
         checkOutput({tag, " m_gnt_o"}, 64'(m_gnt_o),
                     (k == gntWait) ? 64'(1 << w) : 64'd0);
         checkOutput({tag, " m_rvalid_o in REQ"}, 64'(m_rvalid_o), 64'd0);
         if (k == gntWait) begin
            checkOutput({tag, " peri_write"}, 64'(peri_write), 64'(mWrite[w]));
            checkOutput({tag, " peri_be"}, 64'(peri_be), 64'(mBe[w]));
            checkOutput({tag, " peri_wdata"}, 64'(peri_wdata), 64'(mWdata[w]));
         end
      end
      req[w] = 1'b0;
      for (int k = 0; k <= rWait; k++) begin
         @(negedge clk);
         applyStimulus(req, 1'b0, k == rWait,
                       (k == rWait) ? rdata : 32'h0BAD_0000 + k);
         #1;
         if (k == rWait) begin
            e = sbq.pop_front();
            checkOutput({tag, " m_rvalid_o"}, 64'(m_rvalid_o), 64'(1 << e.owner));
            checkOutput({tag, " m_rdata_o"}, 64'(m_rdata_o), 64'(e.rdata));
         end else begin
            checkOutput({tag, " m_rvalid_o wait"}, 64'(m_rvalid_o), 64'd0);
         end
      end
      mAddr[w] = savedAddr;
      modelPtr = (w + 1) % NM;
   endtask

   // Hard stop in case the bench itself stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] time limit");
   end

   initial begin
      mAddr[0]  = 32'h1A10_0000;
      mAddr[1]  = 32'h1A10_0010;
      mBe[0]    = 4'hF;
      mBe[1]    = 4'h3;
      mWdata[0] = 32'h0000_0055;
      mWdata[1] = 32'h0000_0000;
      mWrite    = 2'b01;

      // Reset with a stray response on the bus: everything must read zero.
      rst = 1'b1;
      applyStimulus(2'b00, 1'b0, 1'b1, 32'h1234_5678);
      @(negedge clk);
      @(negedge clk);
      #1;
      checkOutput("reset m_gnt_o", 64'(m_gnt_o), 64'd0);
      checkOutput("reset m_rvalid_o", 64'(m_rvalid_o), 64'd0);
      checkOutput("reset m_rdata_o", 64'(m_rdata_o), 64'd0);
      checkOutput("reset peri_req", 64'(peri_req), 64'd0);
      checkOutput("reset peri_addr", 64'(peri_addr), 64'd0);
      checkOutput("reset peri_write", 64'(peri_write), 64'd0);
      checkOutput("reset peri_be", 64'(peri_be), 64'd0);
      checkOutput("reset peri_wdata", 64'(peri_wdata), 64'd0);
      checkOutput("reset timeout_o", 64'(timeout_o), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);

      $display("[TB] single master 0 write, zero wait");
      serveTxn(2'b01, 0, 0, 32'h0, 1'b0, 1'b0, "m0 write");

      $display("[TB] master 1 read, five wait cycles");
      serveTxn(2'b10, 0, 5, 32'hCAFE_0001, 1'b0, 1'b0, "m1 read");

      $display("[TB] both masters requesting, four rounds");
      for (int i = 0; i < 4; i++) begin
         serveTxn(2'b11, i % 2, 1, 32'h0000_0100 + i, 1'b0, i == 1, "rr");
      end

      $display("[TB] master 0 drops req before gnt");
      serveTxn(2'b01, 2, 1, 32'h0000_0077, 1'b1, 1'b0, "drop early");

      // Reset while waiting for a response; the late response is stale.
      $display("[TB] reset during WAIT_R");
      @(negedge clk);
      applyStimulus(2'b01, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      applyStimulus(2'b01, 1'b1, 1'b0, 32'h0);
      #1;
      checkOutput("rst-wait m_gnt_o", 64'(m_gnt_o), 64'd1);
      @(negedge clk);
      applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
      #1;
      checkOutput("rst-wait pending m_rvalid_o", 64'(m_rvalid_o), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(2'b00, 1'b0, 1'b1, 32'h5757_5757);
      #1;
      checkOutput("stale m_rvalid_o", 64'(m_rvalid_o), 64'd0);
      checkOutput("stale m_rdata_o", 64'(m_rdata_o), 64'd0);
      checkOutput("post-reset peri_addr", 64'(peri_addr), 64'd0);
      checkOutput("post-reset peri_req", 64'(peri_req), 64'd0);
      modelPtr = 0;
      serveTxn(2'b11, 0, 0, 32'h0000_0099, 1'b0, 1'b0, "post-reset rr");

      // Response with nothing outstanding is dropped.
      @(negedge clk);
      applyStimulus(2'b00, 1'b0, 1'b1, 32'h4444_4444);
      #1;
      checkOutput("idle rvalid m_rvalid_o", 64'(m_rvalid_o), 64'd0);

`ifdef PERI_ARB_TIMEOUT_EN
      $display("[TB] response watchdog");
      @(negedge clk);
      applyStimulus(2'b10, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      applyStimulus(2'b10, 1'b1, 1'b0, 32'h0);
      #1;
      checkOutput("to m_gnt_o", 64'(m_gnt_o), 64'd2);
      for (int k = 0; k <= TO; k++) begin
         @(negedge clk);
         applyStimulus(2'b00, 1'b0, 1'b0, 32'h1111_1111);
         #1;
         if (k < TO) begin
            checkOutput("to waiting m_rvalid_o", 64'(m_rvalid_o), 64'd0);
         end else begin
            checkOutput("to m_rvalid_o", 64'(m_rvalid_o), 64'd2);
            checkOutput("to m_rdata_o", 64'(m_rdata_o), 64'hDEAD_BEEF);
         end
      end
      @(negedge clk);
      applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
      #1;
      checkOutput("to timeout_o set", 64'(timeout_o), 64'd1);
      checkOutput("to no extra m_rvalid_o", 64'(m_rvalid_o), 64'd0);
      modelPtr = 0;
      serveTxn(2'b01, 0, 0, 32'h0000_00AA, 1'b0, 1'b0, "after timeout");
      #1;
      checkOutput("to timeout_o sticky", 64'(timeout_o), 64'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("to timeout_o cleared", 64'(timeout_o), 64'd0);
`else
      #1;
      checkOutput("timeout_o tied low", 64'(timeout_o), 64'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule
